servo_slew_ctrl: RTL and testbench
==================================

Name: servo_slew_ctrl

Overview:
Upstream command stage for the servo PWM generators. It accepts per-channel target pulse widths over a valid/ready interface. Each channel's output width moves toward its target in rate-limited steps on a slow tick, which prevents servo jerk. Each width_us output slice drives one servo_pwm instance directly and replaces the free-running sweep logic in the arm top level.

Parameters:
NUM_CH, 5, number of servo channels (1..8)
TICK_DIV, 250000, clk cycles per slew tick (200 Hz at 50 MHz); must be > NUM_CH+1
STEP_US, 10, maximum width change per channel per tick, in us
MIN_US, 1000, lower clamp for targets, in us
MAX_US, 2000, upper clamp for targets, in us
INIT_US, 1500, reset value of all widths and targets, in us

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_ch  in  3  target channel index
cmd_width  in  16  requested pulse width, us
cmd_err  out  1  one-cycle pulse: accepted command had cmd_ch >= NUM_CH
busy  out  NUM_CH  bit i high while width i != target i
width_us_flat  out  16*NUM_CH  current widths; channel i occupies bits [16i+15:16i]

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n). All state clears immediately when rst_n is low.
- Reset values: every width and target = INIT_US; busy = 0; cmd_err = 0; tick counter = 0; FSM = IDLE; cmd_ready = 1 after reset releases.
- Tick counter: counts 0..TICK_DIV-1 and wraps. A tick pulse is asserted for the one cycle in which the count equals TICK_DIV-1.
- FSM states: IDLE and SWEEP.
  - IDLE: cmd_ready = 1. On a tick, go to SWEEP with idx = 0.
  - SWEEP: cmd_ready = 0. Each cycle, update channel idx and increment idx. When idx = NUM_CH-1, return to IDLE.
  - A sweep lasts exactly NUM_CH cycles. Because TICK_DIV > NUM_CH+1, a tick never arrives during SWEEP.
- Command accept: a command is accepted when cmd_valid && cmd_ready.
  - On the same clock edge, target[cmd_ch] <= clamp(cmd_width, MIN_US, MAX_US).
  - Width outputs are not altered directly by a command.
- Invalid channel (cmd_ch >= NUM_CH): the command is still accepted (handshake completes). No target changes. cmd_err = 1 for the following cycle only.
- Tick and command in the same IDLE cycle: the command is accepted, and its target is written at the same edge that enters SWEEP. The sweep therefore uses the new target.
- Step rule for channel i during SWEEP:
  - If width < target: width <= min(width + STEP_US, target).
  - If width > target: width <= max(width - STEP_US, target).
  - If equal: no change.
  - Width never overshoots the target and never leaves [MIN_US, MAX_US].
- Arithmetic: internal compares are 17 bits wide so that add/subtract cannot wrap.
- busy: registered, updated in the same cycle as the width or target change it reflects. busy[i] = (next width i != next target i).
- Retargeting mid-ramp: the new target applies from the next sweep, and direction may reverse. There is no queue; the last accepted command per channel wins.
- Outputs are registered: width changes appear 1 cycle after the SWEEP cycle that processes that channel.
- Reset mid-sweep or mid-ramp: outputs return immediately to INIT_US and any in-flight sweep is abandoned.

Test Plan:
Bench uses TICK_DIV=16 and defaults otherwise.
1. Hold rst_n low, then release -> all widths 1500, busy=0, cmd_ready=1, cmd_err=0. First tick at cycle 15 -> cmd_ready low for exactly 5 cycles.
2. cmd ch2=2000 -> busy[2]=1; width2 rises 10 per tick, 1510..2000, reaching 2000 after 50 ticks, then busy[2]=0. Other channels stay at 1500.
3. Clamp check: cmd ch0=2500 -> target 2000. cmd ch1=900 -> target 1000, reached after 50 ticks. cmd ch3=1505 -> reaches 1505 after one tick (partial step).
4. Reversal: ch4 ramping toward 2000, at width 1600 send ch4=1550 -> next tick 1590, then 1580, ..., reaching 1550 after 5 ticks with no overshoot.
5. cmd_ch=7 -> handshake completes, cmd_err high for 1 cycle, all targets unchanged. A cmd_valid held during SWEEP stalls until IDLE, then is accepted.
6. Command issued in the tick cycle (ch0=1000) -> accepted, and width0=1490 on that sweep. Assert rst_n low mid-ramp -> widths immediately 1500, busy=0.

Source files
------------

// File: rtl/servo_slew_ctrl.sv
// Rate-limited servo pulse-width command stage: accepts per-channel targets and
// walks each channel's width toward its target by at most STEP_US per slew tick.
module servo_slew_ctrl #(
  parameter int NUM_CH   = 5,
  parameter int TICK_DIV = 250000,
  parameter int STEP_US  = 10,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int INIT_US  = 1500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_ch,
  input  logic [15:0]           cmd_width,
  output logic                  cmd_err,
  output logic [NUM_CH-1:0]     busy,
  output logic [16*NUM_CH-1:0]  width_us_flat
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [2:0]       r_idx;
  logic [2:0]       w_idxNext;
  logic [CNT_W-1:0] r_tickCnt;
  logic             w_tick;
  logic             w_accept;
  logic             w_chValid;
  logic [15:0]      w_clamped;
  logic             r_cmdErr;

  assign w_tick    = (r_tickCnt == CNT_W'(TICK_DIV - 1));
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_chValid = ({1'b0, cmd_ch} < 4'(NUM_CH));
  assign w_clamped = (cmd_width < 16'(MIN_US)) ? 16'(MIN_US) :
                     (cmd_width > 16'(MAX_US)) ? 16'(MAX_US) : cmd_width;
  assign cmd_err   = r_cmdErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_cmdErr <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_idx    <= w_idxNext;
      r_cmdErr <= w_accept && !w_chValid;
    end
  end

  // Commands are only taken in IDLE, so a target never changes mid-sweep.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    cmd_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (w_tick) begin
          w_stateNext = SWEEP;
          w_idxNext   = '0;
        end
      end
      SWEEP: begin
        if (r_idx == 3'(NUM_CH - 1)) begin
          w_stateNext = IDLE;
        end else begin
          w_idxNext = r_idx + 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic [15:0] r_width;
    logic [15:0] r_target;
    logic        r_busy;
    logic [15:0] w_widthNext;
    logic [15:0] w_targetNext;
    logic [16:0] w_cur;
    logic [16:0] w_tgt;
    logic [16:0] w_up;
    logic [16:0] w_dnLim;
    logic        w_sel;

    // 17-bit arithmetic so the step add cannot wrap before the compare.
    assign w_cur   = {1'b0, r_width};
    assign w_tgt   = {1'b0, r_target};
    assign w_up    = w_cur + 17'(STEP_US);
    assign w_dnLim = w_tgt + 17'(STEP_US);
    assign w_sel   = (r_state == SWEEP) && (r_idx == 3'(g));

    always_comb begin
      w_widthNext  = r_width;
      w_targetNext = r_target;
      if (w_sel) begin
        if (w_cur < w_tgt) begin
          w_widthNext = (w_up > w_tgt) ? r_target : w_up[15:0];
        end else if (w_cur > w_tgt) begin
          w_widthNext = (w_cur < w_dnLim) ? r_target : 16'(w_cur - 17'(STEP_US));
        end
      end
      if (w_accept && w_chValid && (cmd_ch == 3'(g))) begin
        w_targetNext = w_clamped;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_width  <= 16'(INIT_US);
        r_target <= 16'(INIT_US);
        r_busy   <= 1'b0;
      end else begin
        r_width  <= w_widthNext;
        r_target <= w_targetNext;
        r_busy   <= (w_widthNext != w_targetNext);
      end
    end

    assign busy[g]                 = r_busy;
    assign width_us_flat[16*g +: 16] = r_width;
  end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Self-checking bench for servo_slew_ctrl: timeline-based reference model,
// table-driven ramp vectors, hand-written corner sequences and random commands.
module tb_servo_slew_ctrl;

  localparam int NUM_CH   = 5;
  localparam int TICK_DIV = 16;
  localparam int STEP_US  = 10;
  localparam int MIN_US   = 1000;
  localparam int MAX_US   = 2000;
  localparam int INIT_US  = 1500;

  logic                 clk;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_ch;
  logic [15:0]          cmd_width;
  logic                 cmd_err;
  logic [NUM_CH-1:0]    busy;
  logic [16*NUM_CH-1:0] width_us_flat;

  int total;
  int bad;

  // Model state: edges since reset release, plus per-channel target/width.
  int mE;
  int mTarget [NUM_CH];
  int mWidth  [NUM_CH];
  int mErr;

  typedef struct {
    int ch;
    int width;
    int ticks;
    int expWidth;
    int expBusy;
  } vec_t;

  vec_t vecs [5];

  servo_slew_ctrl #(
    .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .STEP_US(STEP_US),
    .MIN_US(MIN_US), .MAX_US(MAX_US), .INIT_US(INIT_US)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_width(cmd_width), .cmd_err(cmd_err),
    .busy(busy), .width_us_flat(width_us_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // The first tick is seen in the cycle after edge TICK_DIV-1, then the block
  // is busy sweeping for NUM_CH cycles after every tick.
  function automatic int modelReady(input int e);
    return ((e < TICK_DIV) || ((e % TICK_DIV) >= NUM_CH)) ? 1 : 0;
  endfunction

  function automatic int clampW(input int w);
    return (w < MIN_US) ? MIN_US : (w > MAX_US) ? MAX_US : w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dutWidth(input int ch);
    return int'(width_us_flat[16*ch +: 16]);
  endfunction

  task automatic modelReset();
    mE  = 0;
    mErr = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      mTarget[i] = INIT_US;
      mWidth[i]  = INIT_US;
    end
  endtask

  task automatic modelEdge(input logic v, input logic [2:0] ch, input logic [15:0] w,
                           output logic acc);
    int diff;
    int sc;
    acc = v && (modelReady(mE) == 1);
    mE++;
    if (mE > TICK_DIV && (mE % TICK_DIV) >= 1 && (mE % TICK_DIV) <= NUM_CH) begin
      sc = (mE % TICK_DIV) - 1;
      diff = mTarget[sc] - mWidth[sc];
      if (diff > STEP_US)       mWidth[sc] = mWidth[sc] + STEP_US;
      else if (diff < -STEP_US) mWidth[sc] = mWidth[sc] - STEP_US;
      else                      mWidth[sc] = mTarget[sc];
    end
    mErr = (acc && int'(ch) >= NUM_CH) ? 1 : 0;
    if (acc && int'(ch) < NUM_CH) mTarget[ch] = clampW(int'(w));
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] ch, input logic [15:0] w);
    cmd_valid = v;
    cmd_ch    = ch;
    cmd_width = w;
  endtask

  task automatic checkOutput();
    chk("cmd_ready", int'(cmd_ready), modelReady(mE));
    chk("cmd_err", int'(cmd_err), mErr);
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("busy%0d", i), int'(busy[i]), (mWidth[i] != mTarget[i]) ? 1 : 0);
      chk($sformatf("width%0d", i), dutWidth(i), mWidth[i]);
    end
  endtask

  task automatic doCycle(input logic v, input logic [2:0] ch, input logic [15:0] w,
                         output logic acc);
    applyStimulus(v, ch, w);
    @(posedge clk);
    modelEdge(v, ch, w, acc);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    logic acc;
    for (int k = 0; k < n; k++) doCycle(1'b0, 3'd0, 16'd0, acc);
  endtask

  task automatic issueCmd(input logic [2:0] ch, input logic [15:0] w);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      doCycle(1'b1, ch, w, acc);
      tries++;
    end
    if (!acc) chk("cmd_accept_timeout", 0, 1);
    applyStimulus(1'b0, 3'd0, 16'd0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 3'd0, 16'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    modelReset();
    checkOutput();
    rst_n = 1'b1;
    checkOutput();
  endtask

  initial begin
    logic acc;
    int   firstLow;
    int   lowCount;
    int   stalls;
    logic readyBefore;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'd0);
    @(negedge clk);

    vecs[0] = '{ch: 2, width: 2000, ticks: 50, expWidth: 2000, expBusy: 0};
    vecs[1] = '{ch: 0, width: 2500, ticks: 50, expWidth: 2000, expBusy: 0};
    vecs[2] = '{ch: 1, width: 900,  ticks: 50, expWidth: 1000, expBusy: 0};
    vecs[3] = '{ch: 3, width: 1505, ticks: 1,  expWidth: 1505, expBusy: 0};
    vecs[4] = '{ch: 2, width: 1730, ticks: 10, expWidth: 1600, expBusy: 1};

    $display("[TB] reset and first tick");
    doReset();
    chk("reset_width0", dutWidth(0), 1500);
    chk("reset_ready", int'(cmd_ready), 1);
    firstLow = -1;
    lowCount = 0;
    for (int k = 1; k <= 24; k++) begin
      doCycle(1'b0, 3'd0, 16'd0, acc);
      if (!cmd_ready) begin
        lowCount++;
        if (firstLow < 0) firstLow = k;
      end
    end
    chk("first_sweep_start", firstLow, 16);
    chk("sweep_len", lowCount, 5);

    $display("[TB] ramp table");
    for (int t = 0; t < 5; t++) begin
      doReset();
      issueCmd(3'(vecs[t].ch), 16'(vecs[t].width));
      runCycles(vecs[t].ticks * TICK_DIV + 8);
      chk($sformatf("vec%0d_width", t), dutWidth(vecs[t].ch), vecs[t].expWidth);
      chk($sformatf("vec%0d_busy", t), int'(busy[vecs[t].ch]), vecs[t].expBusy);
    end

    $display("[TB] reversal");
    doReset();
    issueCmd(3'd4, 16'd2000);
    runCycles(169);
    chk("rev_start", dutWidth(4), 1600);
    issueCmd(3'd4, 16'd1550);
    runCycles(16);
    chk("rev_first", dutWidth(4), 1590);
    runCycles(64);
    chk("rev_final", dutWidth(4), 1550);
    chk("rev_busy", int'(busy[4]), 0);

    $display("[TB] invalid channel and stall");
    doReset();
    issueCmd(3'd7, 16'd1234);
    chk("err_pulse", int'(cmd_err), 1);
    runCycles(1);
    chk("err_clear", int'(cmd_err), 0);
    chk("err_busy", int'(busy), 0);
    doReset();
    runCycles(16);
    stalls = 0;
    readyBefore = cmd_ready;
    while (!readyBefore && stalls < 20) begin
      doCycle(1'b1, 3'd1, 16'd1800, acc);
      stalls++;
      readyBefore = cmd_ready;
    end
    doCycle(1'b1, 3'd1, 16'd1800, acc);
    applyStimulus(1'b0, 3'd0, 16'd0);
    chk("stall_cycles", stalls, 5);
    chk("stall_busy1", int'(busy[1]), 1);

    $display("[TB] command in tick cycle and async reset");
    doReset();
    runCycles(15);
    issueCmd(3'd0, 16'd1000);
    runCycles(1);
    chk("tick_cmd_width0", dutWidth(0), 1490);
    runCycles(40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_width0", dutWidth(0), 1500);
    chk("async_busy", int'(busy), 0);
    chk("async_ready", int'(cmd_ready), 1);
    doReset();

    $display("[TB] random commands");
    for (int k = 0; k < 1500; k++) begin
      logic        v;
      logic [2:0]  ch;
      logic [15:0] w;
      v  = ($urandom % 3) == 0;
      ch = 3'($urandom % 8);
      w  = (($urandom % 4) == 0) ? 16'($urandom_range(1490, 1510))
                                 : 16'($urandom_range(700, 2300));
      doCycle(v, ch, w, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
